// File: rtl/nn_pkg.sv
// nn_pkg: shared types, constants and width helpers for the MLP layer sequencer
package nn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  typedef enum logic [2:0] {IDLE, CLR, ACC, DRAIN, WB, DONE} seq_state_e;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/nn_wrap_counter.sv
// nn_wrap_counter: up-counter that wraps to zero after reaching limit, flagging the terminal value
module nn_wrap_counter
  import nn_pkg::*;
#(
  parameter int MAX_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [MAX_W-1:0] limit,
  output logic [MAX_W-1:0] count,
  output logic             last
);
  logic [MAX_W-1:0] count_q, count_d;
  assign count = count_q;
  assign last  = count_q == limit;
  // clear wins over enable; enable at the terminal value wraps to zero
  always_comb count_d = clr ? '0 : en ? (last ? '0 : count_q + MAX_W'(1)) : count_q;
  // count register
  always_ff @(posedge clk_in)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: neuron-by-neuron controller sharing one MAC across a 2-layer MLP
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int IN_FEATURES  = 11,
  parameter int HIDDEN       = 11,
  parameter int OUT_FEATURES = 1,
  parameter int MAC_LATENCY  = 2,
  localparam int IDX_W    = cw(max3(IN_FEATURES, HIDDEN, OUT_FEATURES) + 1),
  localparam int W_ADDR_W = cw(IN_FEATURES * HIDDEN + HIDDEN * OUT_FEATURES),
  localparam int B_ADDR_W = cw(HIDDEN + OUT_FEATURES)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_ready,
  output logic                busy,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic [B_ADDR_W-1:0] b_addr,
  output logic                fbuf_rd_sel,
  output logic [IDX_W-1:0]    fbuf_rd_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                wb_v,
  output logic                wb_sel,
  output logic [IDX_W-1:0]    wb_addr,
  output logic                relu_en,
  output logic                data_out_v
);
  localparam int DR_W = cw(MAC_LATENCY);
  seq_state_e state_q, state_d;
  logic l_q, l_d;
  logic [IDX_W-1:0] j, k, j_lim, k_lim;
  logic [DR_W-1:0] d_cnt, d_lim;
  logic j_last, k_last, d_last, idle;
  logic [W_ADDR_W-1:0] w_addr_q;
  logic [B_ADDR_W-1:0] b_addr_q;
  logic sel_q, wb_sel_q;
  logic [IDX_W-1:0] faddr_q, wb_addr_q;

  assign idle  = state_q == IDLE;
  assign j_lim = IDX_W'(l_q ? OUT_FEATURES - 1 : HIDDEN - 1);
  assign k_lim = IDX_W'(l_q ? HIDDEN - 1 : IN_FEATURES - 1);
  assign d_lim = DR_W'(MAC_LATENCY == 0 ? 0 : MAC_LATENCY - 1);

  nn_wrap_counter #(.MAX_W(IDX_W)) u_j (
    .clk_in(clk_in), .rst_n(rst_n), .en(state_q == WB), .clr(idle),
    .limit(j_lim), .count(j), .last(j_last)
  );
  nn_wrap_counter #(.MAX_W(IDX_W)) u_k (
    .clk_in(clk_in), .rst_n(rst_n), .en(state_q == ACC), .clr(idle),
    .limit(k_lim), .count(k), .last(k_last)
  );
  nn_wrap_counter #(.MAX_W(DR_W)) u_drain (
    .clk_in(clk_in), .rst_n(rst_n), .en(state_q == DRAIN), .clr(idle),
    .limit(d_lim), .count(d_cnt), .last(d_last)
  );

  // phase sequencing: clear, accumulate K_L terms, wait out the MAC pipeline, write back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_v ? CLR : IDLE;
      CLR:     state_d = ACC;
      ACC:     state_d = k_last ? ((MAC_LATENCY == 0) ? WB : DRAIN) : ACC;
      DRAIN:   state_d = d_last ? WB : DRAIN;
      WB:      state_d = (j_last && l_q) ? DONE : CLR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // layer flag flips after the last hidden neuron and is cleared whenever idle
  always_comb l_d = idle ? 1'b0 : (state_q == WB && j_last) ? 1'b1 : l_q;

  assign in_ready   = idle;
  assign busy       = ~idle;
  assign mac_clr    = state_q == CLR;
  assign mac_en     = state_q == ACC;
  assign wb_v       = state_q == WB;
  assign relu_en    = wb_v & ~l_q;
  assign data_out_v = state_q == DONE;

  // addresses are driven in their own phase and hold their last value otherwise
  always_comb begin
    b_addr       = mac_clr ? B_ADDR_W'(l_q ? HIDDEN : 0) + B_ADDR_W'(j) : b_addr_q;
    w_addr       = mac_en ? W_ADDR_W'(l_q ? IN_FEATURES * HIDDEN : 0)
                   + W_ADDR_W'(j) * W_ADDR_W'(l_q ? HIDDEN : IN_FEATURES) + W_ADDR_W'(k) : w_addr_q;
    fbuf_rd_sel  = mac_en ? l_q : sel_q;
    fbuf_rd_addr = mac_en ? k : faddr_q;
    wb_sel       = wb_v ? l_q : wb_sel_q;
    wb_addr      = wb_v ? j : wb_addr_q;
  end

  // state, layer and address-hold registers
  always_ff @(posedge clk_in)
    if (!rst_n) begin
      state_q   <= IDLE;
      l_q       <= 1'b0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      sel_q     <= 1'b0;
      faddr_q   <= '0;
      wb_sel_q  <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      w_addr_q  <= w_addr;
      b_addr_q  <= b_addr;
      sel_q     <= fbuf_rd_sel;
      faddr_q   <= fbuf_rd_addr;
      wb_sel_q  <= wb_sel;
      wb_addr_q <= wb_addr;
    end

  // the drain counter never runs past its terminal value
  a_drain_bound: assert property (@(posedge clk_in) disable iff (!rst_n)
    (state_q != DRAIN) || (d_cnt <= d_lim));
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scoreboard bench for default and reduced-size sequencer configurations
module tb_nn_layer_sequencer;
  localparam int IW = 4, WW = 8, BW = 4;
  localparam int SIW = 2, SWW = 4, SBW = 3;
  typedef struct {int kind; int cyc; int addr; int aux;} ev_t;

  logic clk = 0, rst_n = 0, in_v = 1, in_v_s = 0;
  logic in_ready, busy, fbuf_rd_sel, mac_clr, mac_en, wb_v, wb_sel, relu_en, data_out_v;
  logic [WW-1:0] w_addr;
  logic [BW-1:0] b_addr;
  logic [IW-1:0] fbuf_rd_addr, wb_addr;
  logic in_ready_s, busy_s, fbuf_rd_sel_s, mac_clr_s, mac_en_s, wb_v_s, wb_sel_s, relu_en_s, data_out_v_s;
  logic [SWW-1:0] w_addr_s;
  logic [SBW-1:0] b_addr_s;
  logic [SIW-1:0] fbuf_rd_addr_s, wb_addr_s;

  ev_t exp_q[$], exp_s[$];
  ev_t me;
  int checks = 0, failures = 0;
  int edge_n = 0, acc_edge = 0, acc_cnt = 0;
  int n_clr = 0, n_en = 0, n_wb = 0, n_done = 0, done_cyc = 0, done_edge = 0;
  int cur, gk, ga, gx;

  nn_layer_sequencer dut (
    .clk_in(clk), .rst_n(rst_n), .in_v(in_v), .in_ready(in_ready), .busy(busy),
    .w_addr(w_addr), .b_addr(b_addr), .fbuf_rd_sel(fbuf_rd_sel), .fbuf_rd_addr(fbuf_rd_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .wb_v(wb_v), .wb_sel(wb_sel), .wb_addr(wb_addr),
    .relu_en(relu_en), .data_out_v(data_out_v)
  );

  nn_layer_sequencer #(.IN_FEATURES(2), .HIDDEN(3), .OUT_FEATURES(2), .MAC_LATENCY(0)) dut_s (
    .clk_in(clk), .rst_n(rst_n), .in_v(in_v_s), .in_ready(in_ready_s), .busy(busy_s),
    .w_addr(w_addr_s), .b_addr(b_addr_s), .fbuf_rd_sel(fbuf_rd_sel_s), .fbuf_rd_addr(fbuf_rd_addr_s),
    .mac_clr(mac_clr_s), .mac_en(mac_en_s), .wb_v(wb_v_s), .wb_sel(wb_sel_s), .wb_addr(wb_addr_s),
    .relu_en(relu_en_s), .data_out_v(data_out_v_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n++;
    if (rst_n === 1'b1 && in_ready === 1'b1 && in_v === 1'b1) begin
      acc_edge = edge_n;
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    cur = edge_n - acc_edge + 1;
    if (mac_en === 1'b1 || wb_v === 1'b1) begin
      checks++;
      if (mac_en === 1'b1 && wb_v === 1'b1) begin
        failures++;
        $display("FAIL overlap: mac_en=%b wb_v=%b at cycle %0d, required not both high", mac_en, wb_v, cur);
      end
    end
    if (|{mac_clr, mac_en, wb_v, data_out_v} === 1'b1) begin
      gk = mac_clr ? 0 : mac_en ? 1 : wb_v ? 2 : 3;
      ga = mac_clr ? int'(b_addr) : mac_en ? int'(w_addr) : wb_v ? int'(wb_addr) : 0;
      gx = mac_en ? int'(fbuf_rd_sel) * 256 + int'(fbuf_rd_addr) : wb_v ? int'(wb_sel) * 2 + int'(relu_en) : 0;
      n_clr += int'(mac_clr);
      n_en  += int'(mac_en);
      n_wb  += int'(wb_v);
      if (data_out_v) begin
        n_done++;
        done_cyc  = cur;
        done_edge = edge_n;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got kind=%0d cyc=%0d addr=%0d aux=%0d, required no event", gk, cur, ga, gx);
      end else begin
        me = exp_q.pop_front();
        if (me.kind != gk || me.cyc != cur || me.addr != ga || me.aux != gx) begin
          failures++;
          $display("FAIL sb_event: got kind=%0d cyc=%0d addr=%0d aux=%0d, required kind=%0d cyc=%0d addr=%0d aux=%0d",
                   gk, cur, ga, gx, me.kind, me.cyc, me.addr, me.aux);
        end
      end
    end
  end

  task automatic gen(input bit s, input int ni, input int nh, input int no, input int lat);
    int c;
    ev_t e;
    c = 1;
    for (int l = 0; l < 2; l++) begin
      int n, kk;
      n  = l ? no : nh;
      kk = l ? nh : ni;
      for (int j = 0; j < n; j++) begin
        e = '{0, c, (l ? nh : 0) + j, 0};
        if (s) exp_s.push_back(e); else exp_q.push_back(e);
        c++;
        for (int k = 0; k < kk; k++) begin
          e = '{1, c, (l ? ni * nh : 0) + j * kk + k, l * 256 + k};
          if (s) exp_s.push_back(e); else exp_q.push_back(e);
          c++;
        end
        c += lat;
        e = '{2, c, j, l * 2 + ((l == 0) ? 1 : 0)};
        if (s) exp_s.push_back(e); else exp_q.push_back(e);
        c++;
      end
    end
    e = '{3, c, 0, 0};
    if (s) exp_s.push_back(e); else exp_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if ({mac_clr, mac_en, wb_v, data_out_v, relu_en, wb_sel, fbuf_rd_sel} !== 7'b0) begin
      failures++; $display("FAIL rst_strobes: got %b required 0000000", {mac_clr, mac_en, wb_v, data_out_v, relu_en, wb_sel, fbuf_rd_sel}); end
    checks++; if ({w_addr, b_addr, fbuf_rd_addr, wb_addr} !== '0) begin
      failures++; $display("FAIL rst_addrs: got %0h required 0", {w_addr, b_addr, fbuf_rd_addr, wb_addr}); end
    checks++; if (in_ready_s !== 1'b1) begin failures++; $display("FAIL rst_small_ready: got %b required 1", in_ready_s); end
    in_v  = 0;
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || n_clr !== 0) begin
      failures++; $display("FAIL rst_in_v_ignored: got in_ready=%b clr=%0d required 1 and 0", in_ready, n_clr); end
  endtask

  task automatic test_defaults();
    n_clr = 0; n_en = 0; n_wb = 0; n_done = 0;
    gen(0, 11, 11, 1, 2);
    @(negedge clk) in_v = 1;
    @(negedge clk) in_v = 0;
    for (int i = 0; i < 400 && n_done == 0; i++) begin @(negedge clk); #1; end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL def_done_count: got %0d required 1", n_done); end
    checks++; if (done_cyc !== 181) begin failures++; $display("FAIL def_done_cycle: got %0d required 181", done_cyc); end
    checks++; if (n_clr !== 12) begin failures++; $display("FAIL def_clr_count: got %0d required 12", n_clr); end
    checks++; if (n_en !== 132) begin failures++; $display("FAIL def_en_count: got %0d required 132", n_en); end
    checks++; if (n_wb !== 12) begin failures++; $display("FAIL def_wb_count: got %0d required 12", n_wb); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL def_sb_left: got %0d required 0", exp_q.size()); end
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL def_idle: got %b required 1", in_ready); end
    checks++; if (w_addr !== 8'd131) begin failures++; $display("FAIL def_w_hold: got %0d required 131", w_addr); end
    checks++; if (b_addr !== 4'd11) begin failures++; $display("FAIL def_b_hold: got %0d required 11", b_addr); end
    checks++; if ({fbuf_rd_sel, fbuf_rd_addr} !== {1'b1, 4'd10}) begin
      failures++; $display("FAIL def_fbuf_hold: got %b/%0d required 1/10", fbuf_rd_sel, fbuf_rd_addr); end
    checks++; if ({wb_sel, wb_addr} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL def_wb_hold: got %b/%0d required 1/0", wb_sel, wb_addr); end
  endtask

  task automatic test_busy_ignore();
    int a0, acc0;
    n_done = 0;
    acc0 = acc_cnt;
    gen(0, 11, 11, 1, 2);
    @(negedge clk) in_v = 1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      in_v = (c == 5 || c == 100);
    end
    #1;
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_done_count: got %0d required 1", n_done); end
    checks++; if (done_cyc !== 181) begin failures++; $display("FAIL busy_done_cycle: got %0d required 181", done_cyc); end
    checks++; if (acc_cnt - acc0 !== 1) begin failures++; $display("FAIL busy_accepts: got %0d required 1", acc_cnt - acc0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL busy_sb_left: got %0d required 0", exp_q.size()); end
    n_done = 0;
    acc0 = acc_cnt;
    gen(0, 11, 11, 1, 2);
    gen(0, 11, 11, 1, 2);
    @(negedge clk) in_v = 1;
    @(negedge clk);
    #1;
    a0 = acc_edge;
    for (int i = 0; i < 800 && n_done < 2; i++) begin @(negedge clk); #1; end
    in_v = 0;
    checks++; if (n_done !== 2) begin failures++; $display("FAIL held_done_count: got %0d required 2", n_done); end
    checks++; if (done_edge - a0 + 1 !== 363) begin failures++; $display("FAIL held_second_done: got %0d required 363", done_edge - a0 + 1); end
    checks++; if (acc_cnt - acc0 !== 2) begin failures++; $display("FAIL held_accepts: got %0d required 2", acc_cnt - acc0); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL held_sb_left: got %0d required 0", exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    gen(0, 11, 11, 1, 2);
    @(negedge clk) in_v = 1;
    @(negedge clk) in_v = 0;
    repeat (6) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_idle: got in_ready=%b busy=%b required 1/0", in_ready, busy); end
    checks++; if ({mac_clr, mac_en, wb_v, data_out_v, relu_en} !== 5'b0) begin
      failures++; $display("FAIL mid_strobes: got %b required 00000", {mac_clr, mac_en, wb_v, data_out_v, relu_en}); end
    checks++; if ({w_addr, fbuf_rd_addr} !== '0) begin
      failures++; $display("FAIL mid_addrs: got %0d/%0d required 0/0", w_addr, fbuf_rd_addr); end
    exp_q.delete();
    rst_n = 1;
    n_clr = 0; n_done = 0;
    gen(0, 11, 11, 1, 2);
    @(negedge clk) in_v = 1;
    @(negedge clk) in_v = 0;
    for (int i = 0; i < 400 && n_done == 0; i++) begin @(negedge clk); #1; end
    checks++; if (done_cyc !== 181 || n_done !== 1) begin
      failures++; $display("FAIL mid_restart_done: got cycle %0d count %0d required 181/1", done_cyc, n_done); end
    checks++; if (n_clr !== 12 || exp_q.size() !== 0) begin
      failures++; $display("FAIL mid_restart_sb: got clr=%0d left=%0d required 12/0", n_clr, exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_small();
    ev_t se;
    int sk, sa, sx, sdone;
    sdone = 0;
    gen(1, 2, 3, 2, 0);
    @(negedge clk) in_v_s = 1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) in_v_s = 0;
      if (mac_en_s === 1'b1 || wb_v_s === 1'b1) begin
        checks++;
        if (mac_en_s === 1'b1 && wb_v_s === 1'b1) begin
          failures++; $display("FAIL small_overlap: got both high at cycle %0d required exclusive", c); end
      end
      if (|{mac_clr_s, mac_en_s, wb_v_s, data_out_v_s} === 1'b1) begin
        sk = mac_clr_s ? 0 : mac_en_s ? 1 : wb_v_s ? 2 : 3;
        sa = mac_clr_s ? int'(b_addr_s) : mac_en_s ? int'(w_addr_s) : wb_v_s ? int'(wb_addr_s) : 0;
        sx = mac_en_s ? int'(fbuf_rd_sel_s) * 256 + int'(fbuf_rd_addr_s) : wb_v_s ? int'(wb_sel_s) * 2 + int'(relu_en_s) : 0;
        if (data_out_v_s) sdone = c;
        checks++;
        if (exp_s.size() == 0) begin
          failures++; $display("FAIL small_unexpected: got kind=%0d cyc=%0d addr=%0d, required no event", sk, c, sa);
        end else begin
          se = exp_s.pop_front();
          if (se.kind != sk || se.cyc != c || se.addr != sa || se.aux != sx) begin
            failures++;
            $display("FAIL small_event: got kind=%0d cyc=%0d addr=%0d aux=%0d, required kind=%0d cyc=%0d addr=%0d aux=%0d",
                     sk, c, sa, sx, se.kind, se.cyc, se.addr, se.aux);
          end
        end
      end
    end
    checks++; if (sdone !== 23) begin failures++; $display("FAIL small_done_cycle: got %0d required 23", sdone); end
    checks++; if (exp_s.size() !== 0) begin failures++; $display("FAIL small_sb_left: got %0d required 0", exp_s.size()); end
    checks++; if (in_ready_s !== 1'b1) begin failures++; $display("FAIL small_idle: got %b required 1", in_ready_s); end
    checks++; if ({w_addr_s, wb_sel_s, wb_addr_s} !== {4'd11, 1'b1, 2'd1}) begin
      failures++; $display("FAIL small_hold: got w=%0d sel=%b wb=%0d required 11/1/1", w_addr_s, wb_sel_s, wb_addr_s); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_busy_ignore();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
